// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES Avalon-MM controller: FSM states, register
// indices and STATUS bit positions.
package aes_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      CAPTURE,
      FINISH
   } aes_state_e;

   // Words 0..11 are backed by storage; START and STATUS are handled separately.
   localparam int NUM_WORDS = 12;

   localparam logic [3:0] REG_KEY0    = 4'd0;
   localparam logic [3:0] REG_MSGIN0  = 4'd4;
   localparam logic [3:0] REG_MSGOUT0 = 4'd8;
   localparam logic [3:0] REG_START   = 4'd14;
   localparam logic [3:0] REG_STATUS  = 4'd15;

   localparam int STAT_DONE    = 0;
   localparam int STAT_TIMEOUT = 1;
   localparam int STAT_BUSY    = 2;

endpackage

// File: rtl/aes_regfile.sv
// 16-word Avalon register file: byte-enabled KEY/MSG_IN words with a write
// lock, read-only MSG_OUT words loaded from the core, START bit and STATUS view.
module aes_regfile (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic         rd_en,
   input  logic [3:0]   addr,
   input  logic [3:0]   byteen,
   input  logic [31:0]  wdata,
   input  logic         wr_lock,
   input  logic         cap_en,
   input  logic [127:0] cap_data,
   input  logic [2:0]   status,
   output logic [31:0]  rdata,
   output logic [127:0] key,
   output logic [127:0] msg_in,
   output logic [31:0]  key_view,
   output logic [31:0]  out_view,
   output logic         start
);
   import aes_ctrl_pkg::*;

   logic [31:0] word [NUM_WORDS];
   logic        start_q, start_d;
   logic [31:0] rdata_q, rdata_d;

   for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic [31:0] word_d, word_q;

      if (gi >= int'(REG_MSGOUT0)) begin : g_ro
         // MSG_OUT words are only ever loaded from the core, word8 taking the MSBs.
         always_comb begin
            word_d = word_q;
            if (cap_en) begin
               word_d = cap_data[127 - 32*(gi - int'(REG_MSGOUT0)) -: 32];
            end
         end
      end else begin : g_rw
         always_comb begin
            word_d = word_q;
            if (wr_en && !wr_lock && (addr == 4'(gi))) begin
               for (int b = 0; b < 4; b++) begin
                  if (byteen[b]) begin
                     word_d[8*b +: 8] = wdata[8*b +: 8];
                  end
               end
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            word_q <= '0;
         end else begin
            word_q <= word_d;
         end
      end

      assign word[gi] = word_q;
   end

   always_comb begin
      start_d = start_q;
      if (wr_en && (addr == REG_START) && byteen[0]) begin
         start_d = wdata[0];
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = '0;
         if (addr < 4'(NUM_WORDS)) begin
            rdata_d = word[addr];
         end else if (addr == REG_START) begin
            rdata_d = {31'b0, start_q};
         end else if (addr == REG_STATUS) begin
            rdata_d = {29'b0, status};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         start_q <= start_d;
         rdata_q <= rdata_d;
      end
   end

   assign key      = {word[REG_KEY0], word[REG_KEY0 + 4'd1], word[REG_KEY0 + 4'd2], word[REG_KEY0 + 4'd3]};
   assign msg_in   = {word[REG_MSGIN0], word[REG_MSGIN0 + 4'd1], word[REG_MSGIN0 + 4'd2], word[REG_MSGIN0 + 4'd3]};
   assign key_view = {word[REG_KEY0][31:16], word[REG_KEY0 + 4'd3][15:0]};
   assign out_view = {word[REG_MSGOUT0][31:16], word[REG_MSGOUT0 + 4'd3][15:0]};
   assign start    = start_q;
   assign rdata    = rdata_q;

endmodule

// File: rtl/aes_avalon_ctrl.sv
// Avalon-MM controller for the AES decryption core: register file, start/done
// sequencing FSM with timeout, and the registered hex-display export conduit.
module aes_avalon_ctrl #(
   parameter int TIMEOUT_CYC = 1024,
   parameter bit EXPORT_SEL  = 1'b1
) (
   input  logic         clk_clk,
   input  logic         reset_reset_n,
   input  logic         avs_chipselect,
   input  logic [3:0]   avs_address,
   input  logic         avs_read,
   input  logic         avs_write,
   input  logic [3:0]   avs_byteenable,
   input  logic [31:0]  avs_writedata,
   output logic [31:0]  avs_readdata,
   output logic         aes_start,
   output logic [127:0] aes_key,
   output logic [127:0] aes_msg_in,
   input  logic [127:0] aes_msg_out,
   input  logic         aes_done,
   output logic [31:0]  aes_export_export_data
);
   import aes_ctrl_pkg::*;

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   aes_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic [31:0]      export_q, export_d;

   logic             start_bit;
   logic             busy;
   logic             wr_lock;
   logic             cap_en;
   logic             export_sel;
   logic [2:0]       status;
   logic [31:0]      key_view, out_view;

   aes_regfile u_regfile (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .wr_en    (avs_chipselect & avs_write),
      .rd_en    (avs_chipselect & avs_read),
      .addr     (avs_address),
      .byteen   (avs_byteenable),
      .wdata    (avs_writedata),
      .wr_lock  (wr_lock),
      .cap_en   (cap_en),
      .cap_data (aes_msg_out),
      .status   (status),
      .rdata    (avs_readdata),
      .key      (aes_key),
      .msg_in   (aes_msg_in),
      .key_view (key_view),
      .out_view (out_view),
      .start    (start_bit)
   );

   assign busy = (state_q == WAIT) || (state_q == CAPTURE);
   // The LAUNCH cycle is locked too so the core never sees operands change after its start pulse.
   assign wr_lock   = busy || (state_q == LAUNCH);
   assign aes_start = (state_q == LAUNCH);

   always_comb begin
      status               = '0;
      status[STAT_DONE]    = done_q;
      status[STAT_TIMEOUT] = timeout_q;
      status[STAT_BUSY]    = busy;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      cap_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_bit && !done_q) begin
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Software abort beats a completing core; completion beats the timeout.
            if (!start_bit) begin
               state_d = IDLE;
            end else if (aes_done) begin
               state_d = CAPTURE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               state_d   = FINISH;
            end
         end
         CAPTURE: begin
            cap_en  = 1'b1;
            done_d  = 1'b1;
            state_d = FINISH;
         end
         FINISH: begin
            if (!start_bit) begin
               done_d    = 1'b0;
               timeout_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign export_sel = EXPORT_SEL;

   always_comb begin
      export_d = export_sel ? out_view : key_view;
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         export_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         export_q  <= export_d;
      end
   end

   assign aes_export_export_data = export_q;

endmodule

// File: tb/tb_aes_avalon_ctrl.sv
// Directed bench for aes_avalon_ctrl: reads are checked by a scoreboard monitor,
// launch/export/conduit observations are checked inline.
module tb_aes_avalon_ctrl;

   logic         clk_clk = 1'b0;
   logic         reset_reset_n;
   logic         avs_chipselect;
   logic [3:0]   avs_address;
   logic         avs_read;
   logic         avs_write;
   logic [3:0]   avs_byteenable;
   logic [31:0]  avs_writedata;
   logic [31:0]  avs_readdata;
   logic         aes_start;
   logic [127:0] aes_key;
   logic [127:0] aes_msg_in;
   logic [127:0] aes_msg_out;
   logic         aes_done;
   logic [31:0]  aes_export_export_data;

   localparam logic [127:0] RET_NORM = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
   localparam logic [127:0] RET_COLL = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          start_cnt = 0;
   bit          core_auto = 1'b0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   aes_avalon_ctrl #(
      .TIMEOUT_CYC (16),
      .EXPORT_SEL  (1'b1)
   ) dut (
      .clk_clk                (clk_clk),
      .reset_reset_n          (reset_reset_n),
      .avs_chipselect         (avs_chipselect),
      .avs_address            (avs_address),
      .avs_read               (avs_read),
      .avs_write              (avs_write),
      .avs_byteenable         (avs_byteenable),
      .avs_writedata          (avs_writedata),
      .avs_readdata           (avs_readdata),
      .aes_start              (aes_start),
      .aes_key                (aes_key),
      .aes_msg_in             (aes_msg_in),
      .aes_msg_out            (aes_msg_out),
      .aes_done               (aes_done),
      .aes_export_export_data (aes_export_export_data)
   );

   initial forever #5 clk_clk = ~clk_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end else begin
         $display("check %s: %h", nm, act);
      end
   endtask

   // Scoreboard monitor: a read strobed at edge N is compared just after edge N.
   initial begin
      bit took;
      forever begin
         @(posedge clk_clk);
         took = avs_chipselect && avs_read && reset_reset_n;
         #1;
         if (took) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_read: got %h required no read", avs_readdata);
            end else begin
               chk(name_q.pop_front(), avs_readdata, exp_q.pop_front());
            end
         end
      end
   end

   // Launch pulse counter (every LAUNCH cycle is one count).
   initial forever begin
      @(negedge clk_clk);
      if (aes_start) start_cnt++;
   end

   // Core model: completes one cycle after its start pulse when enabled.
   initial forever begin
      @(negedge clk_clk);
      if (aes_start && core_auto) begin
         @(negedge clk_clk);
         aes_done    = 1'b1;
         aes_msg_out = RET_NORM;
         @(negedge clk_clk);
         aes_done    = 1'b0;
      end
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk_clk);
      avs_chipselect = 1'b1;
      avs_write      = 1'b1;
      avs_address    = a;
      avs_writedata  = d;
      avs_byteenable = be;
      @(negedge clk_clk);
      avs_chipselect = 1'b0;
      avs_write      = 1'b0;
      avs_byteenable = 4'h0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
      @(negedge clk_clk);
      avs_chipselect = 1'b1;
      avs_read       = 1'b1;
      avs_address    = a;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk_clk);
      avs_chipselect = 1'b0;
      avs_read       = 1'b0;
   endtask

   // Returns at the negedge inside the LAUNCH cycle.
   task automatic wait_start(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk_clk);
         if (aes_start) seen = 1'b1;
      end
      chk(nm, seen, 1'b1);
   endtask

   initial begin
      int s0;
      reset_reset_n  = 1'b0;
      avs_chipselect = 1'b0;
      avs_address    = 4'h0;
      avs_read       = 1'b0;
      avs_write      = 1'b0;
      avs_byteenable = 4'h0;
      avs_writedata  = 32'h0;
      aes_msg_out    = '0;
      aes_done       = 1'b0;
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;

      // Reset state
      for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, $sformatf("reset_rd_%0d", a));
      chk("reset_aes_start", aes_start, 1'b0);
      chk("reset_export", aes_export_export_data, 32'h0);

      // Byte-enable write
      wr(4'd0, 32'hDEADBEEF, 4'b0101);
      rd(4'd0, 32'h00AD00EF, "byteen_wr");

      // Normal run
      wr(4'd0, 32'h00010203, 4'hF);
      wr(4'd1, 32'h04050607, 4'hF);
      wr(4'd2, 32'h08090A0B, 4'hF);
      wr(4'd3, 32'h0C0D0E0F, 4'hF);
      for (int a = 4; a < 8; a++) wr(4'(a), 32'h11111111, 4'hF);
      rd(4'd3, 32'h0C0D0E0F, "key3_rd");
      chk("aes_key_view", aes_key, 128'h000102030405060708090A0B0C0D0E0F);
      chk("aes_msg_in_view", aes_msg_in, {4{32'h11111111}});
      core_auto = 1'b1;
      s0 = start_cnt;
      wr(4'd14, 32'h1, 4'hF);
      repeat (8) @(negedge clk_clk);
      core_auto = 1'b0;
      chk("norm_start_pulses", 32'(start_cnt - s0), 32'd1);
      rd(4'd15, 32'h1, "norm_status_done");
      rd(4'd8,  32'hA5A5A5A5, "norm_out0");
      rd(4'd9,  32'h5A5A5A5A, "norm_out1");
      rd(4'd10, 32'h01234567, "norm_out2");
      rd(4'd11, 32'h89ABCDEF, "norm_out3");
      rd(4'd14, 32'h1, "norm_start_rd");
      chk("norm_export", aes_export_export_data, 32'hA5A5CDEF);
      wr(4'd14, 32'h0, 4'hF);
      rd(4'd15, 32'h0, "norm_status_clr");

      // Timeout with a write attempted during WAIT
      wr(4'd14, 32'h1, 4'hF);
      wait_start("to_launch");
      wr(4'd4, 32'hFFFFFFFF, 4'hF);
      chk("lock_msg_in", aes_msg_in, {4{32'h11111111}});
      repeat (14) @(negedge clk_clk);
      avs_chipselect = 1'b1;
      avs_read       = 1'b1;
      avs_address    = 4'd15;
      exp_q.push_back(32'h4);
      name_q.push_back("to_status_busy");
      @(negedge clk_clk);
      exp_q.push_back(32'h3);
      name_q.push_back("to_status_timeout");
      @(negedge clk_clk);
      avs_chipselect = 1'b0;
      avs_read       = 1'b0;
      rd(4'd8,  32'hA5A5A5A5, "to_out0_kept");
      rd(4'd11, 32'h89ABCDEF, "to_out3_kept");
      rd(4'd4,  32'h11111111, "lock_rd4");
      wr(4'd14, 32'h0, 4'hF);
      rd(4'd15, 32'h0, "to_status_clr");

      // Abort by clearing START, then a late aes_done
      s0 = start_cnt;
      wr(4'd14, 32'h1, 4'hF);
      wait_start("ab_launch");
      wr(4'd14, 32'h0, 4'hF);
      aes_msg_out = {4{32'hFFFFFFFF}};
      aes_done    = 1'b1;
      repeat (2) @(negedge clk_clk);
      aes_done    = 1'b0;
      repeat (2) @(negedge clk_clk);
      chk("ab_start_pulses", 32'(start_cnt - s0), 32'd1);
      rd(4'd15, 32'h0, "ab_status");
      rd(4'd8,  32'hA5A5A5A5, "ab_out0_kept");

      // Reset during WAIT
      wr(4'd14, 32'h1, 4'hF);
      wait_start("rst_launch");
      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      chk("rst_aes_start", aes_start, 1'b0);
      chk("rst_export", aes_export_export_data, 32'h0);
      chk("rst_readdata", avs_readdata, 32'h0);
      reset_reset_n = 1'b1;
      s0 = start_cnt;
      aes_done = 1'b1;
      @(negedge clk_clk);
      aes_done = 1'b0;
      rd(4'd0,  32'h0, "rst_key0");
      rd(4'd4,  32'h0, "rst_msgin0");
      rd(4'd8,  32'h0, "rst_out0");
      rd(4'd14, 32'h0, "rst_start");
      rd(4'd15, 32'h0, "rst_status");
      chk("rst_no_launch", 32'(start_cnt - s0), 32'd0);

      // aes_done on the final timeout cycle
      wr(4'd14, 32'h1, 4'hF);
      wait_start("coll_launch");
      repeat (16) @(negedge clk_clk);
      aes_msg_out = RET_COLL;
      aes_done    = 1'b1;
      @(negedge clk_clk);
      aes_done    = 1'b0;
      repeat (3) @(negedge clk_clk);
      rd(4'd15, 32'h1, "coll_status");
      rd(4'd8,  32'h13579BDF, "coll_out0");
      rd(4'd11, 32'h76543210, "coll_out3");
      chk("coll_export", aes_export_export_data, 32'h13573210);
      wr(4'd14, 32'h0, 4'hF);
      rd(4'd15, 32'h0, "coll_status_clr");

      repeat (3) @(negedge clk_clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_avalon_ctrl.md
Name: aes_avalon_ctrl

Overview:
Avalon-MM slave controller that owns the AES decryption core inside lab7_soc. Software on the Nios II writes the key and ciphertext into a 16-word register file, then sets START. The block sequences the core through a start/done handshake, captures the plaintext and raises DONE. It also drives the 32-bit aes_export conduit, which shows results on the hex displays.

Parameters:
TIMEOUT_CYC, 1024, maximum number of cycles to wait for aes_done before the operation aborts with an error
EXPORT_SEL, 1, 1: export shows {out_word0[31:16], out_word3[15:0]}; 0: export shows {key_word0[31:16], key_word3[15:0]}

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  synchronous active-low reset
avs_chipselect  in  1  slave select
avs_address  in  4  word address 0-15
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_byteenable  in  4  byte lanes for writes
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered, read latency 1
aes_start  out  1  one-cycle start pulse to the core
aes_key  out  128  {word0..word3}, word0 in the MSBs
aes_msg_in  out  128  ciphertext {word4..word7}
aes_msg_out  in  128  plaintext from the core
aes_done  in  1  core completion, level or pulse
aes_export_export_data  out  32  display conduit

Behaviour:
- Synchronous reset (reset_reset_n low at a clk_clk edge):
  - All 16 registers are 0.
  - FSM is in IDLE.
  - avs_readdata, aes_start and aes_export_export_data are all 0.
  - Reset mid-operation aborts the operation immediately; a later aes_done is ignored.
- Register map:
  - 0-3: KEY, R/W.
  - 4-7: MSG_IN, R/W.
  - 8-11: MSG_OUT, read-only.
  - 12-13: reserved, read 0, writes ignored.
  - 14: START, R/W, bit0 used.
  - 15: STATUS, read-only. bit0 = DONE, bit1 = TIMEOUT, bit2 = BUSY, other bits 0.
- Writes:
  - Take effect at the clock edge where avs_chipselect and avs_write are both high.
  - Only byte lanes with avs_byteenable set are updated.
  - Writes to KEY and MSG_IN while BUSY are dropped.
  - Writes to read-only registers are dropped.
- Reads: when avs_chipselect and avs_read are high at edge N, avs_readdata holds that register's value at edge N+1. Otherwise avs_readdata holds its previous value.
- FSM states:
  - IDLE:
    - When START bit0 is 1 and DONE is 0, go to LAUNCH.
    - The START write that triggers this takes effect at edge N; LAUNCH is entered at edge N+1.
  - LAUNCH:
    - aes_start = 1 for exactly this one cycle.
    - Clear the timeout counter and set BUSY.
    - Go to WAIT.
  - WAIT:
    - The counter increments every cycle.
    - When aes_done = 1, go to CAPTURE.
    - Otherwise, when the counter reaches TIMEOUT_CYC-1, set TIMEOUT and go to FINISH without updating MSG_OUT.
    - If aes_done = 1 in the same cycle the counter reaches its limit, aes_done wins.
  - CAPTURE: latch aes_msg_out into words 8-11 (MSB into word8), then go to FINISH.
  - FINISH:
    - Set DONE, clear BUSY.
    - Stay here while START bit0 = 1.
    - When software writes START = 0: clear DONE and TIMEOUT, go to IDLE.
- START rules:
  - Clearing START during WAIT aborts the operation: go to IDLE, clear BUSY, leave MSG_OUT unchanged.
  - Setting START while BUSY has no further effect; there is no re-launch.
- Latency: at least 4 cycles from the START write edge to DONE = 1, for a core that asserts aes_done one cycle after aes_start.
- aes_key and aes_msg_in are continuous views of the register file. They are stable throughout BUSY because register writes are locked.
- aes_export_export_data is registered and updates one cycle after its source registers change.

Decomposition:
- Shared package aes_ctrl_pkg, containing:
  - state enum {IDLE, LAUNCH, WAIT, CAPTURE, FINISH};
  - register index constants (REG_KEY0 = 0, REG_MSGIN0 = 4, REG_MSGOUT0 = 8, REG_START = 14, REG_STATUS = 15);
  - STATUS bit positions.
- One sub-module, aes_regfile: the 16x32 byte-enabled register file with write-lock and capture ports.
- The FSM, counter and export mux stay in the top module.

Test Plan:
- Reset check: after reset, read every address -> 0x00000000. aes_start stays 0 and the export conduit is 0.
- Byte-enable write: write 0xDEADBEEF with byteenable 4'b0101 to address 0, which previously held 0 -> reading address 0 returns 0x00AD00EF.
- Normal run:
  - Load KEY = 000102030405060708090A0B0C0D0E0F and MSG_IN = 0x11.. pattern, then write START = 1.
  - Single aes_start pulse; the core model returns 0xA5A5A5A5_5A5A5A5A_01234567_89ABCDEF with aes_done.
  - STATUS reads 0x1; MSG_OUT words match the returned value; export = 0xA5A5CDEF.
  - Write START = 0 -> STATUS reads 0x0.
- Timeout: with TIMEOUT_CYC = 16 and aes_done held low -> STATUS = 0x3 exactly 16 cycles after LAUNCH, and MSG_OUT is unchanged.
- Write lock: during WAIT, write 0xFFFFFFFF to address 4 -> aes_msg_in is unchanged, and reading address 4 later returns the old value.
- Abort and collisions:
  - Clear START during WAIT, then assert aes_done -> no capture, STATUS = 0x0.
  - Assert reset during WAIT -> all registers and outputs are 0 on the next cycle.
  - aes_done arriving on the final timeout cycle -> CAPTURE is taken and TIMEOUT stays 0.
